// File: rtl/chirp_framer_pkg.sv
// Shared constants and FSM encoding for the per-chirp acquisition framer.
// The frame is: sync header, frame counter, samples, status trailer.
package chirp_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_CNT  = 3'd3,
        ST_DATA = 3'd4,
        ST_TRL  = 3'd5
    } state_t;

    localparam logic [7:0] SYNC0 = 8'hA5;
    localparam logic [7:0] SYNC1 = 8'h5A;

    localparam int TRL_OVF_BIT    = 0;
    localparam int TRL_MISSED_BIT = 1;

endpackage

// File: rtl/chirp_framer_sync_fifo.sv
// Single-clock FIFO with registered read data (valid the cycle after rd_en_i).
// A pop on a full FIFO frees space for a push in the same cycle.
module chirp_framer_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_wr, do_rd;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_rd   = rd_en_i && !empty_o;
    assign do_wr   = wr_en_i && (!full_o || do_rd);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage and read data are datapath only; no reset needed.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
        if (do_rd) rd_data_o <= mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/chirp_framer.sv
// Captures SAMPLES multi-channel strobes per chirp and serialises them as a
// fixed-length byte frame with sync header, counter and status trailer.
module chirp_framer
    import chirp_framer_pkg::*;
#(
    parameter int OW      = 14,
    parameter int NCHAN   = 2,
    parameter int SAMPLES = 1024,
    parameter int DEPTH   = 512,
    parameter int USBDW   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  ramp_start_i,
    input  logic                  sample_valid_i,
    input  logic [NCHAN*OW-1:0]   sample_i,
    output logic [USBDW-1:0]      data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  ovf_o
);
    localparam int EW    = NCHAN * 16;
    localparam int LASTB = 2 * NCHAN - 1;
    localparam int BW    = (2 * NCHAN > 2) ? $clog2(2 * NCHAN) : 1;
    localparam int CW    = $clog2(SAMPLES + 1);

    function automatic logic [15:0] sext16(input logic signed [OW-1:0] s);
        return 16'(s);
    endfunction

    function automatic logic [EW-1:0] expand(input logic [NCHAN*OW-1:0] raw);
        logic [EW-1:0] e;
        for (int c = 0; c < NCHAN; c++) e[c*16 +: 16] = sext16(raw[c*OW +: OW]);
        return e;
    endfunction

    // Byte k of an entry: channel k/2, even k is the MSB.
    function automatic logic [7:0] pick_byte(input logic [EW-1:0] e, input logic [BW-1:0] idx);
        logic [15:0] w;
        w = e[(int'(idx) >> 1) * 16 +: 16];
        return idx[0] ? w[7:0] : w[15:8];
    endfunction

    state_t               state_q;
    logic [USBDW-1:0]     data_q;
    logic                 valid_q, busy_q, ovf_o_q;
    logic [7:0]           frame_cnt_q;
    logic                 ovf_q, missed_q, cap_open_q;
    logic [CW-1:0]        cap_cnt_q, fetch_cnt_q;
    logic                 pend_q, pad_q, ebuf_vld_q, all_loaded_q;
    logic [EW-1:0]        ebuf_q;
    logic [BW-1:0]        bidx_q;

    logic                 fifo_full, fifo_empty, fifo_rd, fifo_wr;
    logic [NCHAN*OW-1:0]  fifo_rdata;
    logic                 out_free, fetch, push_req, drop, start;
    logic [EW-1:0]        src_entry;
    logic [7:0]           trailer;

    chirp_framer_sync_fifo #(.WIDTH(NCHAN*OW), .DEPTH(DEPTH)) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wr_en_i  (fifo_wr),
        .wr_data_i(sample_i),
        .rd_en_i  (fifo_rd),
        .rd_data_o(fifo_rdata),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

    // Fetch the next entry while the last byte of the current one leaves, so
    // the FIFO read latency is hidden; after an overflow an empty FIFO means
    // the rest of the frame is zero padding.
    always_comb begin
        start     = (state_q == ST_IDLE) && ramp_start_i && en_i;
        out_free  = !valid_q || ready_i;
        fetch     = (state_q == ST_DATA) && (fetch_cnt_q != CW'(SAMPLES)) && !pend_q &&
                    (!ebuf_vld_q || (out_free && bidx_q == BW'(LASTB))) &&
                    (!fifo_empty || ovf_q);
        fifo_rd   = fetch && !fifo_empty;
        push_req  = sample_valid_i && cap_open_q;
        fifo_wr   = push_req && (!fifo_full || fifo_rd);
        drop      = push_req && fifo_full && !fifo_rd;
        src_entry = pad_q ? '0 : expand(fifo_rdata);
        trailer   = '0;
        trailer[TRL_OVF_BIT]    = ovf_q;
        trailer[TRL_MISSED_BIT] = missed_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            data_q       <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_cnt_q  <= '0;
            fetch_cnt_q  <= '0;
            pend_q       <= 1'b0;
            pad_q        <= 1'b0;
            ebuf_vld_q   <= 1'b0;
            bidx_q       <= '0;
            all_loaded_q <= 1'b0;
        end else begin
            pend_q <= fetch;
            pad_q  <= fetch && fifo_empty;
            if (fetch) fetch_cnt_q <= fetch_cnt_q + CW'(1);
            case (state_q)
                ST_IDLE: if (start) begin
                    state_q      <= ST_HDR0;
                    data_q       <= SYNC0;
                    valid_q      <= 1'b1;
                    busy_q       <= 1'b1;
                    fetch_cnt_q  <= '0;
                    ebuf_vld_q   <= 1'b0;
                    bidx_q       <= '0;
                    all_loaded_q <= 1'b0;
                end
                ST_HDR0: if (ready_i) begin
                    state_q <= ST_HDR1;
                    data_q  <= SYNC1;
                end
                ST_HDR1: if (ready_i) begin
                    state_q <= ST_CNT;
                    data_q  <= frame_cnt_q;
                end
                ST_CNT: if (ready_i) begin
                    state_q <= ST_DATA;
                    valid_q <= 1'b0;
                end
                ST_DATA: begin
                    if (all_loaded_q) begin
                        if (ready_i) begin
                            state_q      <= ST_TRL;
                            data_q       <= trailer;
                            all_loaded_q <= 1'b0;
                        end
                    end else if (out_free) begin
                        if (pend_q) begin
                            data_q     <= pick_byte(src_entry, '0);
                            valid_q    <= 1'b1;
                            bidx_q     <= BW'(1);
                            ebuf_vld_q <= 1'b1;
                        end else if (ebuf_vld_q) begin
                            data_q  <= pick_byte(ebuf_q, bidx_q);
                            valid_q <= 1'b1;
                            if (bidx_q == BW'(LASTB)) begin
                                bidx_q     <= '0;
                                ebuf_vld_q <= 1'b0;
                                if (fetch_cnt_q == CW'(SAMPLES)) all_loaded_q <= 1'b1;
                            end else begin
                                bidx_q <= bidx_q + BW'(1);
                            end
                        end else begin
                            valid_q <= 1'b0;
                        end
                    end else if (pend_q) begin
                        bidx_q     <= '0;
                        ebuf_vld_q <= 1'b1;
                    end
                end
                ST_TRL: if (ready_i) begin
                    state_q     <= ST_IDLE;
                    valid_q     <= 1'b0;
                    busy_q      <= 1'b0;
                    frame_cnt_q <= frame_cnt_q + 8'd1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if ((state_q == ST_DATA) && pend_q) ebuf_q <= src_entry;
    end

    // Capture window and status flags; the window opens the cycle after start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cap_open_q <= 1'b0;
            cap_cnt_q  <= '0;
            ovf_q      <= 1'b0;
            missed_q   <= 1'b0;
            ovf_o_q    <= 1'b0;
        end else begin
            ovf_o_q <= drop;
            if (start) begin
                cap_open_q <= 1'b1;
                cap_cnt_q  <= '0;
                ovf_q      <= 1'b0;
                missed_q   <= 1'b0;
            end else begin
                if (fifo_wr) begin
                    cap_cnt_q <= cap_cnt_q + CW'(1);
                    if (cap_cnt_q == CW'(SAMPLES - 1)) cap_open_q <= 1'b0;
                end
                if (drop) begin
                    cap_open_q <= 1'b0;
                    ovf_q      <= 1'b1;
                end
                if (ramp_start_i && busy_q) missed_q <= 1'b1;
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign ovf_o   = ovf_o_q;

endmodule

// File: tb/tb_chirp_framer.sv
// Directed bench for chirp_framer: basic frame, backpressure, overflow,
// missed chirp, counter wrap and mid-frame reset.
module tb_chirp_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        ramp = 1'b0;
    logic        sv = 1'b0;
    logic [27:0] sample = '0;
    logic        ready = 1'b1;

    logic [7:0]  data_a, data_b;
    logic        valid_a, valid_b, busy_a, busy_b, ovf_a, ovf_b;

    always #5 clk = ~clk;

    chirp_framer #(.OW(14), .NCHAN(2), .SAMPLES(4), .DEPTH(8), .USBDW(8)) dut_a (
        .clk_i(clk), .rst_i(rst), .en_i(en), .ramp_start_i(ramp),
        .sample_valid_i(sv), .sample_i(sample), .data_o(data_a), .valid_o(valid_a),
        .ready_i(ready), .busy_o(busy_a), .ovf_o(ovf_a)
    );

    chirp_framer #(.OW(14), .NCHAN(2), .SAMPLES(8), .DEPTH(2), .USBDW(8)) dut_b (
        .clk_i(clk), .rst_i(rst), .en_i(en), .ramp_start_i(ramp),
        .sample_valid_i(sv), .sample_i(sample), .data_o(data_b), .valid_o(valid_b),
        .ready_i(ready), .busy_o(busy_b), .ovf_o(ovf_b)
    );

    typedef struct {
        logic signed [13:0] ch0;
        logic signed [13:0] ch1;
        logic [31:0]        exp;
    } vec_t;

    vec_t       vec [6];
    logic [7:0] qa[$], qb[$], expq[$];
    int         tests = 0, fails = 0, viol = 0;
    logic       stall_a = 1'b0, stall_b = 1'b0;
    logic [7:0] hold_a = '0, hold_b = '0;

    // Accepted-byte collectors plus hold-stable check while stalled.
    always @(negedge clk) begin
        if (rst) begin
            stall_a = 1'b0;
            stall_b = 1'b0;
        end else begin
            if (stall_a && !(valid_a && data_a == hold_a)) viol++;
            if (stall_b && !(valid_b && data_b == hold_b)) viol++;
            if (valid_a && ready) qa.push_back(data_a);
            if (valid_b && ready) qb.push_back(data_b);
            stall_a = valid_a && !ready;
            stall_b = valid_b && !ready;
            hold_a  = data_a;
            hold_b  = data_b;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; ramp = 1'b0; sv = 1'b0; ready = 1'b1; en = 1'b1;
        tick(); tick();
        rst = 1'b0;
        qa.delete(); qb.delete();
    endtask

    task automatic strobe_row(input int r);
        sv = 1'b1;
        sample = {vec[r].ch1, vec[r].ch0};
        tick();
        sv = 1'b0;
    endtask

    task automatic wait_idle(input bit which, input int budget);
        int n = 0;
        while ((which ? busy_b : busy_a) && n < budget) begin
            tick();
            n++;
        end
        ready = 1'b1;
        check(which ? "idle_b" : "idle_a", {31'b0, (which ? busy_b : busy_a)}, 32'd0);
    endtask

    task automatic make_exp(input logic [7:0] cnt, input int r0, input int r1,
                            input int r2, input int r3, input logic [7:0] trl);
        int rows [4];
        rows = '{r0, r1, r2, r3};
        expq.delete();
        expq.push_back(8'hA5); expq.push_back(8'h5A); expq.push_back(cnt);
        for (int i = 0; i < 4; i++)
            for (int b = 3; b >= 0; b--) expq.push_back(vec[rows[i]].exp[b*8 +: 8]);
        expq.push_back(trl);
    endtask

    task automatic cmp_frame(input string nm, input bit which);
        logic [7:0] act[$];
        int         n;
        act = which ? qb : qa;
        check({nm, "_len"}, act.size(), expq.size());
        n = (act.size() < expq.size()) ? act.size() : expq.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_b%0d", nm, i), act[i], expq[i]);
    endtask

    // One frame on dut_a with rows r0..r3; optional backpressure and a
    // ramp pulse while the frame is still busy.
    task automatic run_frame(input int r0, input int r1, input int r2, input int r3,
                             input bit bp, input bit mid_ramp);
        int rows [4];
        int n = 0;
        rows = '{r0, r1, r2, r3};
        qa.delete();
        ramp = 1'b1;
        tick();
        ramp = 1'b0;
        check("start_valid", {31'b0, valid_a}, 32'd1);
        check("start_byte", {24'b0, data_a}, 32'hA5);
        check("start_busy", {31'b0, busy_a}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (bp) ready = 1'($urandom_range(0, 1));
            strobe_row(rows[i]);
        end
        if (mid_ramp) begin
            ramp = 1'b1;
            tick();
            ramp = 1'b0;
        end
        while (busy_a && n < 400) begin
            if (bp) ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        wait_idle(1'b0, 10);
    endtask

    initial begin
        vec[0] = '{14'sd0,  14'sd0,  32'h0000_0000};
        vec[1] = '{14'sd1, -14'sd1,  32'h0001_FFFF};
        vec[2] = '{14'sd2, -14'sd2,  32'h0002_FFFE};
        vec[3] = '{14'sd3, -14'sd3,  32'h0003_FFFD};
        vec[4] = '{14'h1FFF, 14'h2000, 32'h1FFF_E000};
        vec[5] = '{14'h3FFF, 14'h0000, 32'hFFFF_0000};

        do_reset();
        check("rst_data", {24'b0, data_a}, 32'd0);
        check("rst_valid", {31'b0, valid_a}, 32'd0);
        check("rst_busy", {31'b0, busy_a}, 32'd0);
        check("rst_ovf", {31'b0, ovf_a}, 32'd0);
        check("rst_valid_b", {31'b0, valid_b}, 32'd0);

        // Basic frame, then the same frame under random backpressure.
        run_frame(0, 1, 2, 3, 1'b0, 1'b0);
        make_exp(8'h00, 0, 1, 2, 3, 8'h00);
        cmp_frame("basic", 1'b0);
        run_frame(0, 1, 2, 3, 1'b1, 1'b0);
        make_exp(8'h01, 0, 1, 2, 3, 8'h00);
        cmp_frame("bp", 1'b0);

        // Overflow on dut_b: DEPTH=2, consumer stalled during capture.
        do_reset();
        ready = 1'b0;
        ramp = 1'b1;
        tick();
        ramp = 1'b0;
        for (int k = 0; k < 8; k++) begin
            strobe_row(k % 4);
            check($sformatf("ovf_pulse_%0d", k), {31'b0, ovf_b}, (k == 2) ? 32'd1 : 32'd0);
        end
        ready = 1'b1;
        wait_idle(1'b1, 200);
        expq.delete();
        expq.push_back(8'hA5); expq.push_back(8'h5A); expq.push_back(8'h00);
        for (int i = 0; i < 2; i++)
            for (int b = 3; b >= 0; b--) expq.push_back(vec[i].exp[b*8 +: 8]);
        for (int i = 0; i < 24; i++) expq.push_back(8'h00);
        expq.push_back(8'h01);
        cmp_frame("ovf", 1'b1);

        // Missed chirp, then no spontaneous restart and en_i gating.
        do_reset();
        run_frame(4, 5, 4, 5, 1'b0, 1'b1);
        make_exp(8'h00, 4, 5, 4, 5, 8'h02);
        cmp_frame("missed", 1'b0);
        for (int i = 0; i < 10; i++) tick();
        check("no_queued_start", {31'b0, busy_a}, 32'd0);
        en = 1'b0;
        ramp = 1'b1;
        tick();
        ramp = 1'b0;
        check("en_low_blocks", {31'b0, busy_a}, 32'd0);
        en = 1'b1;
        run_frame(0, 1, 2, 3, 1'b0, 1'b0);
        make_exp(8'h01, 0, 1, 2, 3, 8'h00);
        cmp_frame("after_missed", 1'b0);

        // Counter wrap across 257 frames.
        do_reset();
        for (int f = 0; f < 257; f++) begin
            run_frame(0, 1, 2, 3, 1'b0, 1'b0);
            check($sformatf("cnt_f%0d", f), (qa.size() > 2) ? {24'b0, qa[2]} : 32'hDEAD,
                  f % 256);
        end

        // Reset in the middle of the data phase.
        begin
            int n = 0;
            qa.delete();
            ramp = 1'b1;
            tick();
            ramp = 1'b0;
            for (int i = 0; i < 4; i++) strobe_row(i);
            while (qa.size() < 6 && n < 100) begin
                tick();
                n++;
            end
            check("mid_data_reached", {31'b0, (qa.size() >= 6)}, 32'd1);
            rst = 1'b1;
            tick();
            check("rst_mid_valid", {31'b0, valid_a}, 32'd0);
            check("rst_mid_busy", {31'b0, busy_a}, 32'd0);
            rst = 1'b0;
            tick();
        end
        run_frame(0, 1, 2, 3, 1'b0, 1'b0);
        make_exp(8'h00, 0, 1, 2, 3, 8'h00);
        cmp_frame("post_rst", 1'b0);

        check("stall_hold", viol, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
